nn_argmax_stage: RTL and testbench

//  Final classifier stage of the MNIST network. Takes the NUM_CLASSES signed output-layer

---
 rtl/nn_pkg.sv | 16 +
 rtl/nn_max_cmp.sv | 24 ++
 rtl/nn_argmax_stage.sv | 100 ++++++++++
 tb/tb_nn_argmax_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared NN package: default sizes, FSM state type and score type.
// Imported by the argmax stage and by the layer stages.
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 16;
  localparam int IDX_W       = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/nn_max_cmp.sv
// Combinational running-max compare: picks candidate or incumbent.
// Ports: first_i, cand_score_i/cand_idx_i, inc_score_i/inc_idx_i -> win_score_o/win_idx_o.
module nn_max_cmp #(
  parameter int SCORE_W = nn_pkg::SCORE_W,
  parameter int IDX_W   = nn_pkg::IDX_W
) (
  input  logic                      first_i,
  input  logic signed [SCORE_W-1:0] cand_score_i,
  input  logic        [IDX_W-1:0]   cand_idx_i,
  input  logic signed [SCORE_W-1:0] inc_score_i,
  input  logic        [IDX_W-1:0]   inc_idx_i,
  output logic signed [SCORE_W-1:0] win_score_o,
  output logic        [IDX_W-1:0]   win_idx_o
);

  logic take;

  // Strict greater-than: ties keep the incumbent (lower index).
  assign take = first_i || (cand_score_i > inc_score_i);

  assign win_score_o = take ? cand_score_i : inc_score_i;
  assign win_idx_o   = take ? cand_idx_i   : inc_idx_i;

endmodule

// File: rtl/nn_argmax_stage.sv
// Argmax over one frame of signed class scores; result held until acked.
// Ports: clk, reset, in_valid/in_ready/in_score/in_last, valid_out/out_ready, digit_out, max_score, err_out.
module nn_argmax_stage #(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int SCORE_W     = nn_pkg::SCORE_W,
  parameter int IDX_W       = nn_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] in_score,
  input  logic                      in_last,
  output logic                      valid_out,
  input  logic                      out_ready,
  output logic        [IDX_W-1:0]   digit_out,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      err_out
);

  import nn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e                    state_q;
  logic        [IDX_W-1:0]   idx_q;
  logic signed [SCORE_W-1:0] best_score_q;
  logic        [IDX_W-1:0]   best_idx_q;
  logic        [IDX_W-1:0]   digit_q;
  logic signed [SCORE_W-1:0] max_q;
  logic                      err_q;

  logic signed [SCORE_W-1:0] win_score;
  logic        [IDX_W-1:0]   win_idx;
  logic                      accept;
  logic                      at_last;
  logic                      frame_end;

  nn_max_cmp #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_cmp (
    .first_i      (idx_q == '0),
    .cand_score_i (in_score),
    .cand_idx_i   (idx_q),
    .inc_score_i  (best_score_q),
    .inc_idx_i    (best_idx_q),
    .win_score_o  (win_score),
    .win_idx_o    (win_idx)
  );

  // Gate with reset so the stage never advertises ready while held in reset.
  assign in_ready  = (state_q == ST_ACCUM) && !reset;
  assign valid_out = (state_q == ST_DONE);
  assign digit_out = digit_q;
  assign max_score = max_q;
  assign err_out   = err_q;

  assign accept    = in_valid && in_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign frame_end = in_last || at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ACCUM;
      idx_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      digit_q      <= '0;
      max_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            best_score_q <= win_score;
            best_idx_q   <= win_idx;
            if (frame_end) begin
              // Result includes this beat; long or short frames flag an error.
              state_q <= ST_DONE;
              idx_q   <= '0;
              digit_q <= win_idx;
              max_q   <= win_score;
              err_q   <= !(in_last && at_last);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_argmax_stage.sv
// Self-checking bench for nn_argmax_stage: directed and random frames.
// Expected results come from a behavioural argmax model over the beat arrays.
module tb_nn_argmax_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_score;
  logic               in_last;
  logic               valid_out;
  logic               out_ready;
  logic        [3:0]  digit_out;
  logic signed [15:0] max_score;
  logic               err_out;

  int errors = 0;
  int checks = 0;

  logic signed [15:0] sa[16];
  bit                 la[16];

  always #5 clk = ~clk;

  nn_argmax_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .in_last   (in_last),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .digit_out (digit_out),
    .max_score (max_score),
    .err_out   (err_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Argmax by definition: first maximum wins; frame ends at a last flag or the 10th score.
  task automatic model(input int n, output int used, output int bi,
                       output logic signed [15:0] bs, output bit e);
    used = n; bi = 0; bs = 0; e = 1;
    for (int k = 0; k < n; k++) begin
      if (k == 0 || sa[k] > bs) begin
        bs = sa[k];
        bi = k;
      end
      if (la[k] || k == 9) begin
        used = k + 1;
        e = !(la[k] && k == 9);
        break;
      end
    end
  endtask

  task automatic play(input string tag, input int n, input int gap);
    int used, bi, w;
    logic signed [15:0] bs;
    bit e;
    model(n, used, bi, bs, e);
    for (int k = 0; k < used; k++) begin
      if (gap > 0) begin
        int g = $urandom_range(0, gap);
        in_valid = 1'b0;
        for (int j = 0; j < g; j++) step();
      end
      in_valid = 1'b1;
      in_score = sa[k];
      in_last  = la[k];
      w = 0;
      while (!in_ready && w < 20) begin
        step();
        w++;
      end
      if (!in_ready) chk({tag, "_rdy"}, 16'(in_ready), 16'd1);
      if (k == used - 1) chk({tag, "_vpre"}, 16'(valid_out), 16'd0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_valid"}, 16'(valid_out), 16'd1);
    chk({tag, "_digit"}, 16'(digit_out), 16'(bi));
    chk({tag, "_max"}, max_score, bs);
    chk({tag, "_err"}, 16'(err_out), 16'(e));
  endtask

  task automatic ack(input string tag);
    logic [3:0]  d;
    logic [15:0] m;
    d = digit_out;
    m = max_score;
    out_ready = 1'b1;
    chk({tag, "_rdyhs"}, 16'(in_ready), 16'd0);
    step();
    out_ready = 1'b0;
    chk({tag, "_vdrop"}, 16'(valid_out), 16'd0);
    chk({tag, "_dkeep"}, 16'(digit_out), 16'(d));
    chk({tag, "_mkeep"}, max_score, m);
    chk({tag, "_rdy1"}, 16'(in_ready), 16'd1);
  endtask

  task automatic load(input int n, input int v[10], input bit lastn);
    for (int k = 0; k < 16; k++) begin
      sa[k] = 0;
      la[k] = 0;
    end
    for (int k = 0; k < n; k++) sa[k] = 16'(v[k]);
    la[n-1] = lastn;
  endtask

  initial begin
    logic [3:0]  d0;
    logic [15:0] m0;
    reset = 1'b1; in_valid = 0; in_score = 0; in_last = 0; out_ready = 0;
    #2;
    chk("rst_rdy", 16'(in_ready), 16'd0);
    chk("rst_valid", 16'(valid_out), 16'd0);
    chk("rst_digit", 16'(digit_out), 16'd0);
    chk("rst_max", max_score, 16'd0);
    chk("rst_err", 16'(err_out), 16'd0);
    step();
    reset = 1'b0;
    step();
    chk("rel_rdy", 16'(in_ready), 16'd1);

    load(10, '{3, -1, 7, 2, 0, 5, 7, 1, -4, 6}, 1);
    play("t1", 10, 0);
    ack("t1");

    load(10, '{-9, -3, -8, -3, -5, -20, -7, -6, -4, -10}, 1);
    play("t2", 10, 0);
    ack("t2");

    load(10, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767}, 1);
    play("t3", 10, 3);

    // Hold result with in_valid asserted during DONE.
    d0 = digit_out;
    m0 = max_score;
    in_valid = 1'b1;
    in_score = 16'sd12345;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_valid", 16'(valid_out), 16'd1);
      chk("t4_rdy", 16'(in_ready), 16'd0);
      chk("t4_digit", 16'(digit_out), 16'(d0));
      chk("t4_max", max_score, m0);
    end
    in_valid = 1'b0;
    ack("t4");
    load(10, '{-2, 5, 1, 5, 0, 0, 0, 0, 0, 4}, 1);
    play("t4n", 10, 0);
    ack("t4n");

    load(4, '{1, 9, 2, 3, 0, 0, 0, 0, 0, 0}, 1);
    play("t5s", 4, 0);
    ack("t5s");
    load(10, '{4, 4, 8, 1, 8, 2, 0, -1, 3, 7}, 0);
    play("t5l", 10, 0);
    ack("t5l");
    load(10, '{2, 6, 1, 0, 3, 5, 9, 9, 1, 1}, 1);
    play("t5n", 10, 0);
    ack("t5n");

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 10);
      for (int k = 0; k < 16; k++) begin
        sa[k] = 16'($urandom);
        la[k] = 0;
      end
      la[n-1] = (n < 10) ? 1'b1 : bit'($urandom_range(0, 1));
      play("rnd", n, 2);
      ack("rnd");
    end

    // Reset mid-frame: big early score must not survive into the next frame.
    sa[0] = 16'sd30000;
    for (int k = 1; k < 6; k++) sa[k] = 16'(k);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_score = sa[k];
      in_last  = 1'b0;
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", 16'(valid_out), 16'd0);
    chk("t6_digit", 16'(digit_out), 16'd0);
    chk("t6_max", max_score, 16'd0);
    chk("t6_err", 16'(err_out), 16'd0);
    chk("t6_rdy", 16'(in_ready), 16'd0);
    step();
    reset = 1'b0;
    step();
    load(10, '{-5, -6, 10, -7, 11, 3, 11, 2, 0, -1}, 1);
    play("t6f", 10, 0);
    ack("t6f");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
